// File: rtl/light_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : light_seq_pkg
// Purpose  : Shared types and constants for the lamp sequencer: command mode
//            encoding, controller state encoding and the pattern each mode
//            starts from.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package light_seq_pkg;

    // Command mode as carried on cmd_mode.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FILL  = 2'd3
    } mode_e;

    // Controller state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Widest lamp bank supported; patterns are held at this width and
    // truncated to the instance's channel count.
    localparam int MAX_CH = 32;

    localparam logic [MAX_CH-1:0] INIT_CHASE = 32'h0000_0001;
    localparam logic [MAX_CH-1:0] INIT_BLINK = 32'hFFFF_FFFF;
    localparam logic [MAX_CH-1:0] INIT_FILL  = 32'h0000_0001;

    // Pattern loaded when a command of the given mode is accepted.
    function automatic logic [MAX_CH-1:0] init_pattern(input mode_e mode);
        logic [MAX_CH-1:0] pat;
        pat = '0;
        case (mode)
            MODE_CHASE: pat = INIT_CHASE;
            MODE_BLINK: pat = INIT_BLINK;
            MODE_FILL:  pat = INIT_FILL;
            default:    pat = '0;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/light_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : light_dwell_timer
// Purpose  : Dwell counter for the lamp sequencer. Counts cycles while not
//            held and flags the terminal count, wrapping to zero on it.
//            A dwell of zero behaves as a dwell of one.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-high reset
//            clear - synchronous clear to zero (wins over counting)
//            hold  - freeze the count
//            dwell - cycles per step
//            tc    - count equals max(dwell,1)-1
// Revision : 1.0  initial release
// ============================================================================
module light_dwell_timer
    import light_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          hold,
    input  logic [DW-1:0] dwell,
    output logic          tc
);

    logic [DW-1:0] r_count;
    logic [DW-1:0] w_term;

    // dwell=0 folds onto dwell=1 so the terminal value never underflows.
    assign w_term = (dwell == '0) ? '0 : (dwell - DW'(1));
    assign tc     = (r_count == w_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!hold) begin
            r_count <= tc ? '0 : (r_count + DW'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/light_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : light_seq_ctrl
// Purpose  : Lamp pattern sequencer. A command selects CHASE, BLINK or FILL
//            with a per-step dwell; the pattern advances every dwell cycles
//            while enable is high and freezes while it is low. Mode OFF
//            returns to idle with all lamps dark.
//            Optional pause watchdog: compile with LIGHT_SEQ_WDOG_EN to add
//            wdog_err and abort a pause lasting WDOG_LIMIT cycles.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            cmd_valid  - command offered
//            cmd_ready  - command accepted when valid and ready at an edge
//            cmd_mode   - 0 OFF, 1 CHASE, 2 BLINK, 3 FILL
//            cmd_dwell  - cycles per pattern step
//            enable     - low pauses the sequence
//            lamp       - registered lamp drive
//            busy       - high in RUN or PAUSE
//            step_pulse - one-cycle pulse with each pattern advance
//            wdog_err   - sticky pause-timeout flag (LIGHT_SEQ_WDOG_EN only)
// Revision : 1.0  initial release
// ============================================================================
module light_seq_ctrl
    import light_seq_pkg::*;
#(
    parameter int N_CH       = 14,
    parameter int DW         = 8,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_mode,
    input  logic [DW-1:0]   cmd_dwell,
    input  logic            enable,
    output logic [N_CH-1:0] lamp,
    output logic            busy,
    output logic            step_pulse
`ifdef LIGHT_SEQ_WDOG_EN
    ,
    output logic            wdog_err
`endif
);

    state_e          r_state;
    state_e          w_state_nxt;
    mode_e           r_mode;
    mode_e           w_mode_nxt;
    logic [DW-1:0]   r_dwell;
    logic [DW-1:0]   w_dwell_nxt;
    logic [N_CH-1:0] r_lamp;
    logic [N_CH-1:0] w_lamp_nxt;
    logic [N_CH-1:0] w_lamp_init;
    logic [N_CH-1:0] w_lamp_adv;
    logic            r_step;
    logic            w_step_nxt;
    logic            r_ready;
    logic            w_accept;
    logic            w_tc;
    logic            w_tmr_clear;
    logic            w_tmr_hold;

`ifdef LIGHT_SEQ_WDOG_EN
    localparam int WCW = $clog2(WDOG_LIMIT + 1);
    logic [WCW-1:0] r_wdog_cnt;
    logic [WCW-1:0] w_wdog_cnt_nxt;
    logic           r_wdog_err;
    logic           w_wdog_err_nxt;
`else
    // Without the watchdog the limit has no effect.
    if (WDOG_LIMIT > 0) begin : g_no_wdog
    end
`endif

    // cmd_ready is a plain register set by the first edge after reset, so
    // it reads 0 for exactly the cycle following reset release.
    assign w_accept   = cmd_valid && r_ready;
    assign cmd_ready  = r_ready;
    assign busy       = (r_state != ST_IDLE);
    assign lamp       = r_lamp;
    assign step_pulse = r_step;

    // Counter restarts on every accepted command and idles at zero; it only
    // advances in RUN, which is what freezes it during PAUSE.
    assign w_tmr_clear = w_accept || (r_state == ST_IDLE);
    assign w_tmr_hold  = (r_state != ST_RUN);

    light_dwell_timer #(
        .DW (DW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_tmr_clear),
        .hold  (w_tmr_hold),
        .dwell (r_dwell),
        .tc    (w_tc)
    );

    assign w_lamp_init = N_CH'(init_pattern(mode_e'(cmd_mode)));

    // Next pattern for the latched mode.
    always_comb begin
        w_lamp_adv = r_lamp;
        case (r_mode)
            MODE_CHASE: w_lamp_adv = {r_lamp[N_CH-2:0], r_lamp[N_CH-1]};
            MODE_BLINK: w_lamp_adv = ~r_lamp;
            MODE_FILL:  w_lamp_adv = (&r_lamp) ? N_CH'(1)
                                               : {r_lamp[N_CH-2:0], 1'b1};
            default:    w_lamp_adv = '0;
        endcase
    end

    // Next-state and output logic. An accepted command overrides whatever
    // the current state would otherwise do in this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_dwell_nxt = r_dwell;
        w_lamp_nxt  = r_lamp;
        w_step_nxt  = 1'b0;
`ifdef LIGHT_SEQ_WDOG_EN
        w_wdog_cnt_nxt = '0;
        w_wdog_err_nxt = r_wdog_err;
`endif
        if (w_accept) begin
`ifdef LIGHT_SEQ_WDOG_EN
            w_wdog_err_nxt = 1'b0;
`endif
            if (mode_e'(cmd_mode) == MODE_OFF) begin
                w_state_nxt = ST_IDLE;
                w_mode_nxt  = MODE_OFF;
                w_lamp_nxt  = '0;
            end else begin
                w_state_nxt = ST_RUN;
                w_mode_nxt  = mode_e'(cmd_mode);
                w_dwell_nxt = cmd_dwell;
                w_lamp_nxt  = w_lamp_init;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_lamp_nxt = '0;
                end
                ST_RUN: begin
                    // The cycle in which enable drops still counts and may
                    // step; the freeze starts once in PAUSE.
                    if (w_tc) begin
                        w_lamp_nxt = w_lamp_adv;
                        w_step_nxt = 1'b1;
                    end
                    if (!enable) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (enable) begin
                        w_state_nxt = ST_RUN;
                    end
`ifdef LIGHT_SEQ_WDOG_EN
                    else if (r_wdog_cnt == WCW'(WDOG_LIMIT - 1)) begin
                        w_state_nxt    = ST_IDLE;
                        w_mode_nxt     = MODE_OFF;
                        w_lamp_nxt     = '0;
                        w_wdog_err_nxt = 1'b1;
                    end else begin
                        w_wdog_cnt_nxt = r_wdog_cnt + WCW'(1);
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_lamp_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_OFF;
            r_dwell <= '0;
            r_lamp  <= '0;
            r_step  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_dwell <= w_dwell_nxt;
            r_lamp  <= w_lamp_nxt;
            r_step  <= w_step_nxt;
            r_ready <= 1'b1;
        end
    end

`ifdef LIGHT_SEQ_WDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            r_wdog_err <= w_wdog_err_nxt;
        end
    end

    assign wdog_err = r_wdog_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_light_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_seq_ctrl
// Purpose  : Self-checking bench for light_seq_ctrl. Two instances: a
//            14-channel one (watchdog limit 16 when compiled in) and a
//            4-channel one. Expected step events (edge number and lamp
//            value) are queued by the stimulus; monitors pop them on every
//            step_pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_light_seq_ctrl;

    typedef struct {
        int          edge_no;
        logic [31:0] lamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 14 channels
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [1:0]  a_mode  = 2'd0;
    logic [7:0]  a_dwell = 8'd0;
    logic        a_en    = 1'b1;
    logic [13:0] a_lamp;
    logic        a_busy;
    logic        a_step;

    // Instance B: 4 channels
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [1:0]  b_mode  = 2'd0;
    logic [7:0]  b_dwell = 8'd0;
    logic        b_en    = 1'b1;
    logic [3:0]  b_lamp;
    logic        b_busy;
    logic        b_step;

`ifdef LIGHT_SEQ_WDOG_EN
    logic a_wdog;
    logic b_wdog;
`endif

    light_seq_ctrl #(.N_CH(14), .DW(8), .WDOG_LIMIT(16)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_mode(a_mode), .cmd_dwell(a_dwell), .enable(a_en),
        .lamp(a_lamp), .busy(a_busy), .step_pulse(a_step)
`ifdef LIGHT_SEQ_WDOG_EN
        , .wdog_err(a_wdog)
`endif
    );

    light_seq_ctrl #(.N_CH(4), .DW(8), .WDOG_LIMIT(16)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_mode(b_mode), .cmd_dwell(b_dwell), .enable(b_en),
        .lamp(b_lamp), .busy(b_busy), .step_pulse(b_step)
`ifdef LIGHT_SEQ_WDOG_EN
        , .wdog_err(b_wdog)
`endif
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t qa[$];
    exp_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && a_step) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_step: unexpected step at edge %0d lamp %h, required no step", cyc, a_lamp);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (a_lamp !== e.lamp[13:0] || cyc != e.edge_no) begin
                    miscompares++;
                    $display("FAIL a_step: lamp %h at edge %0d, required lamp %h at edge %0d",
                             a_lamp, cyc, e.lamp[13:0], e.edge_no);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_step) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_step: unexpected step at edge %0d lamp %h, required no step", cyc, b_lamp);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (b_lamp !== e.lamp[3:0] || cyc != e.edge_no) begin
                    miscompares++;
                    $display("FAIL b_step: lamp %h at edge %0d, required lamp %h at edge %0d",
                             b_lamp, cyc, e.lamp[3:0], e.edge_no);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_a(input int e, input logic [31:0] l);
        exp_t x;
        x.edge_no = e;
        x.lamp    = l;
        qa.push_back(x);
    endtask

    task automatic push_b(input int e, input logic [31:0] l);
        exp_t x;
        x.edge_no = e;
        x.lamp    = l;
        qb.push_back(x);
    endtask

    task automatic expect_empty(input string name, input int remaining);
        vectors++;
        if (remaining != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected steps not seen, required 0", name, remaining);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic cmd_a(input logic [1:0] m, input logic [7:0] d, output int e0);
        a_mode  = m;
        a_dwell = d;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        e0      = cyc;
    endtask

    task automatic cmd_b(input logic [1:0] m, input logic [7:0] d, output int e0);
        b_mode  = m;
        b_dwell = d;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        e0      = cyc;
    endtask

    task automatic wait_to(input int e);
        if (e > cyc) begin
            repeat (e - cyc) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int e1;
        int ed;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_lamp",  32'(a_lamp),  32'h0);
        check("rst_busy",  32'(a_busy),  32'h0);
        check("rst_ready", 32'(a_ready), 32'h0);
        check("rst_step",  32'(a_step),  32'h0);
`ifdef LIGHT_SEQ_WDOG_EN
        check("rst_wdog",  32'(a_wdog),  32'h0);
`endif
        #3;
        rst = 1'b0;
        #1;
        check("ready_after_release", 32'(a_ready), 32'h0);
        @(posedge clk);
        #1;
        check("ready_one_cycle_later", 32'(a_ready), 32'h1);

        // CHASE, dwell 2, 14 channels: step every 2 edges, wraps after 14
        cmd_a(2'd1, 8'd2, e0);
        check("chase_init_lamp", 32'(a_lamp), 32'h1);
        check("chase_busy",      32'(a_busy), 32'h1);
        for (int k = 1; k <= 14; k++)
            push_a(e0 + 2 * k, (k == 14) ? 32'h1 : (32'h1 << k));
        wait_to(e0 + 28);
        cmd_a(2'd0, 8'd0, ed);
        check("off_lamp", 32'(a_lamp), 32'h0);
        check("off_busy", 32'(a_busy), 32'h0);
        expect_empty("chase_steps", qa.size());

        // FILL, dwell 0, 4 channels: 3,7,F,1 on consecutive edges; an OFF
        // command on the next step edge wins over the step
        cmd_b(2'd3, 8'd0, e0);
        check("fill_init_lamp", 32'(b_lamp), 32'h1);
        push_b(e0 + 1, 32'h3);
        push_b(e0 + 2, 32'h7);
        push_b(e0 + 3, 32'hF);
        push_b(e0 + 4, 32'h1);
        wait_to(e0 + 4);
        cmd_b(2'd0, 8'd0, ed);
        check("fill_off_lamp", 32'(b_lamp), 32'h0);
        check("fill_off_step", 32'(b_step), 32'h0);
        expect_empty("fill_steps", qb.size());

        // BLINK, dwell 3, enable low for 10 edges after one count
        cmd_a(2'd2, 8'd3, e0);
        a_en = 1'b0;
        check("blink_init_lamp", 32'(a_lamp), 32'h3FFF);
        push_a(e0 + 13, 32'h0);
        push_a(e0 + 16, 32'h3FFF);
        wait_to(e0 + 5);
        check("pause_lamp", 32'(a_lamp), 32'h3FFF);
        check("pause_busy", 32'(a_busy), 32'h1);
        check("pause_step", 32'(a_step), 32'h0);
        wait_to(e0 + 10);
        a_en = 1'b1;
        wait_to(e0 + 12);
        check("resume_lamp_before_step", 32'(a_lamp), 32'h3FFF);
        wait_to(e0 + 16);
        cmd_a(2'd0, 8'd0, ed);
        expect_empty("blink_pause_steps", qa.size());

        // CHASE command on the same edge as a BLINK step
        cmd_a(2'd2, 8'd2, e0);
        push_a(e0 + 2, 32'h0);
        wait_to(e0 + 3);
        cmd_a(2'd1, 8'd2, e1);
        check("collide_lamp", 32'(a_lamp), 32'h1);
        check("collide_step", 32'(a_step), 32'h0);
        push_a(e1 + 2, 32'h2);
        wait_to(e1 + 2);
        cmd_a(2'd0, 8'd0, ed);
        expect_empty("collide_steps", qa.size());

        // Asynchronous reset pulse mid-RUN
        cmd_a(2'd1, 8'd5, e0);
        wait_to(e0 + 2);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_lamp",  32'(a_lamp),  32'h0);
        check("async_rst_busy",  32'(a_busy),  32'h0);
        check("async_rst_ready", 32'(a_ready), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("rel_ready_low", 32'(a_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rel_ready_high", 32'(a_ready), 32'h1);
        wait_to(cyc + 6);
        check("rst_discard_lamp", 32'(a_lamp), 32'h0);
        check("rst_discard_busy", 32'(a_busy), 32'h0);

`ifdef LIGHT_SEQ_WDOG_EN
        // Pause watchdog, limit 16
        cmd_a(2'd1, 8'd100, e0);
        a_en = 1'b0;
        for (int n = 0; n < 30 && !a_wdog; n++) begin
            @(posedge clk);
            #1;
        end
        check("wdog_trip", 32'(a_wdog), 32'h1);
        check("wdog_lamp", 32'(a_lamp), 32'h0);
        check("wdog_busy", 32'(a_busy), 32'h0);
        wait_to(cyc + 3);
        check("wdog_sticky", 32'(a_wdog), 32'h1);
        a_en = 1'b1;
        cmd_a(2'd0, 8'd0, ed);
        check("wdog_cleared", 32'(a_wdog), 32'h0);
`endif

        wait_to(cyc + 4);
        expect_empty("final_a", qa.size());
        expect_empty("final_b", qb.size());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
